// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_ctrl
// Brief    : EX-stage branch resolution, mispredict flush/redirect,
//            2-bit saturating branch history table and branch perf counters.
// Revision : 1.0
// ============================================================================
module branch_ctrl #(
    parameter int BHT_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] i_if_pc,
    output logic        o_pred_taken,
    input  logic        i_ex_valid,
    input  logic [2:0]  i_ex_funct3,
    input  logic [31:0] i_ex_pc,
    input  logic [31:0] i_ex_target,
    input  logic        i_ex_pred_taken,
    input  logic        i_stall,
    output logic        o_brun,
    input  logic        i_brlt,
    input  logic        i_breq,
    output logic        o_flush,
    output logic [31:0] o_redirect_pc,
    output logic        o_br_illegal,
    output logic [31:0] o_perf_branches,
    output logic [31:0] o_perf_mispred
);

    localparam int         c_IDX_W    = $clog2(BHT_DEPTH);
    localparam logic [1:0] c_BHT_INIT = 2'b01;
    localparam logic [1:0] c_SAT_MAX  = 2'b11;
    localparam logic [1:0] c_SAT_MIN  = 2'b00;

    logic [1:0]         r_bht [BHT_DEPTH];
    logic               r_flush;
    logic               r_br_illegal;
    logic [31:0]        r_redirect_pc;
    logic [31:0]        r_perf_branches;
    logic [31:0]        r_perf_mispred;

    logic [c_IDX_W-1:0] w_if_idx;
    logic [c_IDX_W-1:0] w_ex_idx;
    logic               w_taken;
    logic               w_illegal;
    logic               w_resolve;
    logic               w_legal;
    logic               w_mispred;
    logic [31:0]        w_pc_plus4;
    logic [1:0]         w_bht_cur;
    logic [1:0]         w_bht_next;
    logic               w_unused_pc_bits;

    assign w_if_idx         = i_if_pc[c_IDX_W+1:2];
    assign w_ex_idx         = i_ex_pc[c_IDX_W+1:2];
    assign w_unused_pc_bits = ^{i_if_pc[31:c_IDX_W+2], i_if_pc[1:0]};

    assign o_pred_taken = r_bht[w_if_idx][1];
    assign o_brun       = i_ex_funct3[2] & i_ex_funct3[1];

    always_comb begin
        w_taken   = 1'b0;
        w_illegal = 1'b0;
        case (i_ex_funct3)
            3'b000:         w_taken   = i_breq;
            3'b001:         w_taken   = ~i_breq;
            3'b100, 3'b110: w_taken   = i_brlt;
            3'b101, 3'b111: w_taken   = ~i_brlt;
            default:        w_illegal = 1'b1;
        endcase
    end

    // The flush term squashes the wrong-path instruction sitting in EX.
    assign w_resolve  = i_ex_valid & ~i_stall & ~r_flush;
    assign w_legal    = w_resolve & ~w_illegal;
    assign w_mispred  = w_legal & (w_taken ^ i_ex_pred_taken);
    assign w_pc_plus4 = i_ex_pc + 32'd4;

    always_comb begin
        w_bht_cur  = r_bht[w_ex_idx];
        w_bht_next = w_bht_cur;
        if (w_taken) begin
            if (w_bht_cur != c_SAT_MAX) w_bht_next = w_bht_cur + 2'd1;
        end else begin
            if (w_bht_cur != c_SAT_MIN) w_bht_next = w_bht_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= c_BHT_INIT;
            end
        end else if (w_legal) begin
            r_bht[w_ex_idx] <= w_bht_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush       <= 1'b0;
            r_br_illegal  <= 1'b0;
            r_redirect_pc <= 32'd0;
        end else begin
            r_flush      <= w_mispred;
            r_br_illegal <= w_resolve & w_illegal;
            if (w_mispred) begin
                r_redirect_pc <= w_taken ? i_ex_target : w_pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_branches <= 32'd0;
            r_perf_mispred  <= 32'd0;
        end else if (w_legal) begin
            if (r_perf_branches != 32'hFFFF_FFFF) begin
                r_perf_branches <= r_perf_branches + 32'd1;
            end
            if (w_mispred && (r_perf_mispred != 32'hFFFF_FFFF)) begin
                r_perf_mispred <= r_perf_mispred + 32'd1;
            end
        end
    end

    assign o_flush         = r_flush;
    assign o_br_illegal    = r_br_illegal;
    assign o_redirect_pc   = r_redirect_pc;
    assign o_perf_branches = r_perf_branches;
    assign o_perf_mispred  = r_perf_mispred;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_ctrl
// Brief    : Scoreboard bench for branch_ctrl with an inline brcmp model.
// Revision : 1.0
// ============================================================================
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] if_pc, ex_pc, ex_target, op_a, op_b;
    logic        ex_valid, ex_pred_taken, stall;
    logic [2:0]  ex_funct3;
    logic        pred_taken, brun, brlt, breq, flush, br_illegal;
    logic [31:0] redirect_pc, perf_branches, perf_mispred;

    always #5 clk = ~clk;

    // Comparator stage driven by the DUT's brun, as in the core.
    assign brlt = brun ? (op_a < op_b) : ($signed(op_a) < $signed(op_b));
    assign breq = (op_a == op_b);

    branch_ctrl #(.BHT_DEPTH(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_if_pc         (if_pc),
        .o_pred_taken    (pred_taken),
        .i_ex_valid      (ex_valid),
        .i_ex_funct3     (ex_funct3),
        .i_ex_pc         (ex_pc),
        .i_ex_target     (ex_target),
        .i_ex_pred_taken (ex_pred_taken),
        .i_stall         (stall),
        .o_brun          (brun),
        .i_brlt          (brlt),
        .i_breq          (breq),
        .o_flush         (flush),
        .o_redirect_pc   (redirect_pc),
        .o_br_illegal    (br_illegal),
        .o_perf_branches (perf_branches),
        .o_perf_mispred  (perf_mispred)
    );

    typedef struct packed {
        logic        flush;
        logic        ill;
        logic [31:0] redir;
        logic [31:0] pb;
        logic [31:0] pm;
    } exp_t;

    exp_t        sbq[$];
    exp_t        e;
    int          total = 0;
    int          bad   = 0;
    logic [1:0]  m_bht [16];
    logic        m_flush, m_ill;
    logic [31:0] m_redir, m_pb, m_pm;
    logic        e_pred, e_brun;

    function automatic logic [3:0] idx(input logic [31:0] pc);
        return pc[5:2];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
        m_flush = 1'b0; m_ill = 1'b0;
        m_redir = 32'd0; m_pb = 32'd0; m_pm = 32'd0;
        sbq.delete();
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pt, input logic st,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] ipc);
        logic lt, taken, ill, res, mis;
        @(negedge clk);
        ex_valid = v; ex_funct3 = f3; ex_pc = pc; ex_target = tgt;
        ex_pred_taken = pt; stall = st; op_a = a; op_b = b; if_pc = ipc;
        e_pred = m_bht[idx(ipc)][1];
        e_brun = (f3 == 3'b110) || (f3 == 3'b111);
        lt     = e_brun ? (a < b) : ($signed(a) < $signed(b));
        ill    = 1'b0;
        taken  = 1'b0;
        case (f3)
            3'b000: taken = (a == b);
            3'b001: taken = (a != b);
            3'b100, 3'b110: taken = lt;
            3'b101, 3'b111: taken = !lt;
            default: ill = 1'b1;
        endcase
        res     = v && !st && !m_flush;
        m_ill   = res && ill;
        m_flush = 1'b0;
        if (res && !ill) begin
            mis     = taken ^ pt;
            m_flush = mis;
            if (mis) m_redir = taken ? tgt : pc + 32'd4;
            if (taken && m_bht[idx(pc)] != 2'b11) m_bht[idx(pc)] = m_bht[idx(pc)] + 2'd1;
            if (!taken && m_bht[idx(pc)] != 2'b00) m_bht[idx(pc)] = m_bht[idx(pc)] - 2'd1;
            if (m_pb != 32'hFFFF_FFFF) m_pb = m_pb + 32'd1;
            if (mis && m_pm != 32'hFFFF_FFFF) m_pm = m_pm + 32'd1;
        end
        sbq.push_back('{m_flush, m_ill, m_redir, m_pb, m_pm});
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        e = sbq.pop_front();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; if_pc = 32'h40; ex_valid = 1'b0; stall = 1'b0;
        ex_funct3 = 3'b000; ex_pc = 32'd0; ex_target = 32'd0; ex_pred_taken = 1'b0;
        op_a = 32'd0; op_b = 32'd0;
        model_reset();
        #12;
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL reset_pred: got %b want 0", pred_taken); end
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL reset_flush: got %b want 0", flush); end
        total++; if (br_illegal !== 1'b0) begin bad++; $display("FAIL reset_ill: got %b want 0", br_illegal); end
        total++; if (redirect_pc !== 32'd0) begin bad++; $display("FAIL reset_redir: got %h want 0", redirect_pc); end
        total++; if (perf_branches !== 32'd0 || perf_mispred !== 32'd0) begin
            bad++; $display("FAIL reset_perf: got %h/%h want 0/0", perf_branches, perf_mispred); end
        @(negedge clk); rst_n = 1'b1;
        tick();
        total++; if (pred_taken !== 1'b0) begin bad++; $display("FAIL post_reset_pred: got %b want 0", pred_taken); end
    endtask

    task automatic test_beq();
        drive(1'b1, 3'b000, 32'h100, 32'h180, 1'b0, 1'b0, 32'd5, 32'd5, 32'h100);
        total++; if (pred_taken !== e_pred) begin bad++; $display("FAIL beq_pred_old: got %b want %b", pred_taken, e_pred); end
        tick(); e = sbq.pop_front();
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL beq_flush: got %b want 1", flush); end
        total++; if (redirect_pc !== 32'h180) begin bad++; $display("FAIL beq_redir: got %h want 180", redirect_pc); end
        total++; if (dut.r_bht[0] !== 2'b10) begin bad++; $display("FAIL beq_bht: got %b want 10", dut.r_bht[0]); end
        drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h100);
        total++; if (pred_taken !== 1'b1) begin bad++; $display("FAIL beq_pred_new: got %b want 1", pred_taken); end
        tick(); e = sbq.pop_front();
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL beq_flush_drop: got %b want 0", flush); end
    endtask

    task automatic test_bltu_blt();
        drive(1'b1, 3'b110, 32'h200, 32'h300, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        total++; if (brun !== 1'b1) begin bad++; $display("FAIL bltu_brun: got %b want 1", brun); end
        tick(); e = sbq.pop_front();
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h204) begin
            bad++; $display("FAIL bltu_redir: got %b/%h want 1/00000204", flush, redirect_pc); end
        idle();
        drive(1'b1, 3'b100, 32'h200, 32'h300, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);
        total++; if (brun !== 1'b0) begin bad++; $display("FAIL blt_brun: got %b want 0", brun); end
        tick(); e = sbq.pop_front();
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL blt_flush: got %b want 0", flush); end
        total++; if (perf_branches !== e.pb || perf_mispred !== e.pm) begin
            bad++; $display("FAIL blt_perf: got %h/%h want %h/%h", perf_branches, perf_mispred, e.pb, e.pm); end
    endtask

    task automatic test_saturation();
        logic [31:0] pb0;
        pb0 = m_pb;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b000, 32'h10C, 32'h500, 1'b1, 1'b0, 32'd7, 32'd7, 32'h10C);
            tick(); e = sbq.pop_front();
        end
        total++; if (dut.r_bht[3] !== 2'b11) begin bad++; $display("FAIL sat_hi: got %b want 11", dut.r_bht[3]); end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b000, 32'h10C, 32'h500, 1'b0, 1'b0, 32'd7, 32'd8, 32'h10C);
            tick(); e = sbq.pop_front();
        end
        total++; if (dut.r_bht[3] !== 2'b00) begin bad++; $display("FAIL sat_lo: got %b want 00", dut.r_bht[3]); end
        total++; if (perf_branches - pb0 !== 32'd8) begin
            bad++; $display("FAIL sat_perf_branches: got +%0d want +8", perf_branches - pb0); end
        drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        force dut.r_perf_mispred = 32'hFFFF_FFFF;
        tick(); e = sbq.pop_front();
        drive(1'b0, 3'b000, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
        release dut.r_perf_mispred;
        m_pm = 32'hFFFF_FFFF;
        tick(); e = sbq.pop_front();
        drive(1'b1, 3'b000, 32'h10C, 32'h500, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0);
        tick(); e = sbq.pop_front();
        total++; if (perf_mispred !== 32'hFFFF_FFFF || flush !== 1'b1) begin
            bad++; $display("FAIL sat_perf_mispred: got %h/%b want ffffffff/1", perf_mispred, flush); end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [1:0] b1;
        b1 = m_bht[1];
        drive(1'b1, 3'b000, 32'h300, 32'h380, 1'b0, 1'b0, 32'd3, 32'd3, 32'd0);
        tick(); e = sbq.pop_front();
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h380) begin
            bad++; $display("FAIL b2b_first: got %b/%h want 1/00000380", flush, redirect_pc); end
        drive(1'b1, 3'b001, 32'h304, 32'h390, 1'b0, 1'b0, 32'd3, 32'd4, 32'd0);
        tick(); e = sbq.pop_front();
        total++; if (flush !== 1'b0 || redirect_pc !== 32'h380) begin
            bad++; $display("FAIL b2b_shadow: got %b/%h want 0/00000380", flush, redirect_pc); end
        total++; if (perf_branches !== e.pb || dut.r_bht[1] !== b1) begin
            bad++; $display("FAIL b2b_noupdate: got %h/%b want %h/%b", perf_branches, dut.r_bht[1], e.pb, b1); end
    endtask

    task automatic test_stall();
        drive(1'b1, 3'b000, 32'h400, 32'h480, 1'b0, 1'b1, 32'd2, 32'd2, 32'd0);
        tick(); e = sbq.pop_front();
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL stall_hold: got %b want 0", flush); end
        drive(1'b1, 3'b000, 32'h400, 32'h480, 1'b0, 1'b0, 32'd2, 32'd2, 32'd0);
        tick(); e = sbq.pop_front();
        total++; if (flush !== 1'b1 || redirect_pc !== 32'h480) begin
            bad++; $display("FAIL stall_release: got %b/%h want 1/00000480", flush, redirect_pc); end
        idle();
    endtask

    task automatic test_illegal();
        logic [1:0]  b0;
        logic [31:0] pb0, pm0;
        b0 = m_bht[0]; pb0 = m_pb; pm0 = m_pm;
        drive(1'b1, 3'b010, 32'h500, 32'h580, 1'b1, 1'b0, 32'd1, 32'd1, 32'd0);
        tick(); e = sbq.pop_front();
        total++; if (br_illegal !== 1'b1 || flush !== 1'b0) begin
            bad++; $display("FAIL ill_pulse: got %b/%b want 1/0", br_illegal, flush); end
        total++; if (dut.r_bht[0] !== b0 || perf_branches !== pb0 || perf_mispred !== pm0) begin
            bad++; $display("FAIL ill_noupdate: got %b/%h/%h want %b/%h/%h",
                            dut.r_bht[0], perf_branches, perf_mispred, b0, pb0, pm0); end
        idle();
        total++; if (br_illegal !== 1'b0) begin bad++; $display("FAIL ill_drop: got %b want 0", br_illegal); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 3'b000, 32'hFFFF_FFFC, 32'h10, 1'b1, 1'b0, 32'd1, 32'd2, 32'd0);
        tick(); e = sbq.pop_front();
        total++; if (flush !== 1'b1 || redirect_pc !== 32'd0) begin
            bad++; $display("FAIL wrap_redir: got %b/%h want 1/00000000", flush, redirect_pc); end
        idle();
    endtask

    task automatic test_random();
        int          bad0;
        logic [31:0] a, b, pc, ipc;
        logic [3:0]  k;
        bad0 = bad;
        for (int i = 0; i < 1000; i++) begin
            a   = 32'($urandom_range(0, 3)) - 32'd1;
            b   = 32'($urandom_range(0, 3)) - 32'd1;
            pc  = {$urandom()} & 32'hFFFF_FFFC;
            ipc = {$urandom()} & 32'hFFFF_FFFC;
            drive(($urandom_range(0, 9) < 7), 3'($urandom()), pc, {$urandom()} & 32'hFFFF_FFFC,
                  1'($urandom()), ($urandom_range(0, 9) < 2), a, b, ipc);
            total++; if (pred_taken !== e_pred || brun !== e_brun) begin
                bad++; $display("FAIL rnd_comb[%0d]: got %b/%b want %b/%b", i, pred_taken, brun, e_pred, e_brun); end
            tick(); e = sbq.pop_front();
            total++; if (flush !== e.flush || br_illegal !== e.ill || redirect_pc !== e.redir) begin
                bad++; $display("FAIL rnd_out[%0d]: got %b/%b/%h want %b/%b/%h",
                                i, flush, br_illegal, redirect_pc, e.flush, e.ill, e.redir); end
            total++; if (perf_branches !== e.pb || perf_mispred !== e.pm) begin
                bad++; $display("FAIL rnd_perf[%0d]: got %h/%h want %h/%h", i, perf_branches, perf_mispred, e.pb, e.pm); end
            k = idx(pc);
            total++; if (dut.r_bht[k] !== m_bht[k]) begin
                bad++; $display("FAIL rnd_bht[%0d]: got %b want %b", i, dut.r_bht[k], m_bht[k]); end
            if (bad != bad0) break;
        end
        idle();
    endtask

    task automatic test_midreset();
        drive(1'b1, 3'b000, 32'h600, 32'h680, 1'b0, 1'b0, 32'd4, 32'd4, 32'h600);
        tick(); e = sbq.pop_front();
        total++; if (flush !== 1'b1) begin bad++; $display("FAIL midrst_pre: got %b want 1", flush); end
        rst_n = 1'b0; ex_valid = 1'b0;
        #1;
        total++; if (flush !== 1'b0) begin bad++; $display("FAIL midrst_flush: got %b want 0", flush); end
        total++; if (dut.r_bht[0] !== 2'b01 || pred_taken !== 1'b0) begin
            bad++; $display("FAIL midrst_bht: got %b/%b want 01/0", dut.r_bht[0], pred_taken); end
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        idle();
        total++; if (perf_branches !== 32'd0 || flush !== 1'b0) begin
            bad++; $display("FAIL midrst_after: got %h/%b want 0/0", perf_branches, flush); end
    endtask

    initial begin
        void'($urandom(32'd20240601));
        test_reset();
        test_beq();
        test_bltu_blt();
        test_saturation();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_wrap();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
